// File: rtl/touch_adc_reader.sv
// rtl/touch_adc_reader.sv - serial initiator for a resistive touch-panel ADC, X/Y pair reader
module touch_adc_reader #(
  parameter int         DIV     = 25,
  parameter int         GAP_CYC = 50,
  parameter logic [7:0] CMD_X   = 8'hD0,
  parameter logic [7:0] CMD_Y   = 8'h90
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        TP_PENIRQ,
  input  logic        TP_DOUT,
  output logic        TP_CS,
  output logic        TP_DCLK,
  output logic        TP_DIN,
  output logic [11:0] xaxis,
  output logic [11:0] yaxis,
  output logic        pen_down,
  output logic        sample_valid
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_SHIFT, S_GAP} state_t;

  localparam logic [15:0] DIV_END = 16'(DIV - 1);
  localparam logic [15:0] GAP_END = 16'(GAP_CYC - 1);
  localparam logic [5:0]  HALF_LAST = 6'd47;

  state_t      r_state, w_state_nxt;
  logic        r_pen_s1, r_pen_s2;
  logic        r_dout_s1, r_dout_s2;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [5:0]  r_half, w_half_nxt;
  logic        r_chan, w_chan_nxt;        // 0 = X frame, 1 = Y frame
  logic        r_pair_ok, w_pair_ok_nxt;  // pen stayed down since the pair began
  logic [11:0] r_shift, w_shift_nxt;
  logic [11:0] r_x_hold, w_x_hold_nxt;
  logic        r_cs, w_cs_nxt;
  logic        r_dclk, w_dclk_nxt;
  logic        r_din, w_din_nxt;
  logic [11:0] r_xaxis, w_xaxis_nxt;
  logic [11:0] r_yaxis, w_yaxis_nxt;
  logic        r_valid, w_valid_nxt;

  logic        w_pen_down;
  logic [7:0]  w_cmd;
  logic [5:0]  w_half_inc;
  logic [4:0]  w_pulse;    // DCLK pulse number the next half-period belongs to
  logic [2:0]  w_din_idx;
  logic        w_ok;

  assign w_pen_down = ~r_pen_s2;
  assign w_cmd      = r_chan ? CMD_Y : CMD_X;
  assign w_half_inc = r_half + 6'd1;
  assign w_pulse    = w_half_inc[5:1] + 5'd1;
  assign w_din_idx  = 3'd7 - w_pulse[2:0];
  assign w_ok       = r_pair_ok & w_pen_down;

  assign TP_CS        = r_cs;
  assign TP_DCLK      = r_dclk;
  assign TP_DIN       = r_din;
  assign xaxis        = r_xaxis;
  assign yaxis        = r_yaxis;
  assign pen_down     = w_pen_down;
  assign sample_valid = r_valid;

  // Next-state and next-output computation for the frame sequencer
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_half_nxt    = r_half;
    w_chan_nxt    = r_chan;
    w_pair_ok_nxt = r_pair_ok;
    w_shift_nxt   = r_shift;
    w_x_hold_nxt  = r_x_hold;
    w_cs_nxt      = r_cs;
    w_dclk_nxt    = r_dclk;
    w_din_nxt     = r_din;
    w_xaxis_nxt   = r_xaxis;
    w_yaxis_nxt   = r_yaxis;
    w_valid_nxt   = 1'b0;

    // Any pen-up moment during a pair disqualifies that pair
    if (r_state != S_IDLE && !w_pen_down) begin
      w_pair_ok_nxt = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        w_cs_nxt   = 1'b1;
        w_dclk_nxt = 1'b0;
        w_din_nxt  = 1'b0;
        if (w_pen_down) begin
          w_state_nxt   = S_START;
          w_chan_nxt    = 1'b0;
          w_pair_ok_nxt = 1'b1;
          w_cnt_nxt     = 16'd0;
          w_cs_nxt      = 1'b0;
          w_din_nxt     = CMD_X[7];
        end
      end
      S_START: begin
        w_cnt_nxt = r_cnt + 16'd1;
        if (r_cnt == DIV_END) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = 16'd0;
          w_half_nxt  = 6'd0;
          w_dclk_nxt  = 1'b1;
        end
      end
      S_SHIFT: begin
        w_cnt_nxt = r_cnt + 16'd1;
        if (r_cnt == DIV_END) begin
          w_cnt_nxt = 16'd0;
          if (r_half == HALF_LAST) begin
            w_state_nxt = S_GAP;
            w_cs_nxt    = 1'b1;
            w_din_nxt   = 1'b0;
          end else begin
            w_half_nxt = w_half_inc;
            w_dclk_nxt = ~w_half_inc[0];
            if (w_half_inc[0]) begin
              // Falling edge: present the next command bit, then zeros
              w_din_nxt = (w_pulse < 5'd8) ? w_cmd[w_din_idx] : 1'b0;
            end else if (w_pulse >= 5'd10 && w_pulse <= 5'd21) begin
              w_shift_nxt = {r_shift[10:0], r_dout_s2};
            end
          end
        end
      end
      S_GAP: begin
        w_cnt_nxt = r_cnt + 16'd1;
        if (r_cnt == GAP_END) begin
          w_cnt_nxt = 16'd0;
          if (!w_ok) begin
            w_state_nxt = S_IDLE;
          end else if (!r_chan) begin
            w_x_hold_nxt = r_shift;
            w_chan_nxt   = 1'b1;
            w_state_nxt  = S_START;
            w_cs_nxt     = 1'b0;
            w_din_nxt    = CMD_Y[7];
          end else begin
            w_xaxis_nxt   = r_x_hold;
            w_yaxis_nxt   = r_shift;
            w_valid_nxt   = 1'b1;
            w_chan_nxt    = 1'b0;
            w_pair_ok_nxt = 1'b1;
            w_state_nxt   = S_START;
            w_cs_nxt      = 1'b0;
            w_din_nxt     = CMD_X[7];
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; reset abandons any frame in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pen_s1  <= 1'b1;
      r_pen_s2  <= 1'b1;
      r_dout_s1 <= 1'b0;
      r_dout_s2 <= 1'b0;
      r_cnt     <= 16'd0;
      r_half    <= 6'd0;
      r_chan    <= 1'b0;
      r_pair_ok <= 1'b0;
      r_shift   <= 12'd0;
      r_x_hold  <= 12'd0;
      r_cs      <= 1'b1;
      r_dclk    <= 1'b0;
      r_din     <= 1'b0;
      r_xaxis   <= 12'd0;
      r_yaxis   <= 12'd0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pen_s1  <= TP_PENIRQ;
      r_pen_s2  <= r_pen_s1;
      r_dout_s1 <= TP_DOUT;
      r_dout_s2 <= r_dout_s1;
      r_cnt     <= w_cnt_nxt;
      r_half    <= w_half_nxt;
      r_chan    <= w_chan_nxt;
      r_pair_ok <= w_pair_ok_nxt;
      r_shift   <= w_shift_nxt;
      r_x_hold  <= w_x_hold_nxt;
      r_cs      <= w_cs_nxt;
      r_dclk    <= w_dclk_nxt;
      r_din     <= w_din_nxt;
      r_xaxis   <= w_xaxis_nxt;
      r_yaxis   <= w_yaxis_nxt;
      r_valid   <= w_valid_nxt;
    end
  end

endmodule

// File: tb/tb_touch_adc_reader.sv
// tb/tb_touch_adc_reader.sv - scoreboard bench with a behavioural touch ADC model
module tb_touch_adc_reader;
  localparam int DIV = 2;
  localparam int GAP = 4;
  localparam int T   = 10;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        penirq = 1'b1;
  logic        dout   = 1'b1;
  logic        cs, dclk, din, pen_down, sample_valid;
  logic [11:0] xaxis, yaxis;

  touch_adc_reader #(.DIV(DIV), .GAP_CYC(GAP), .CMD_X(8'hD0), .CMD_Y(8'h90)) dut (
    .clk(clk), .rst_n(rst_n), .TP_PENIRQ(penirq), .TP_DOUT(dout),
    .TP_CS(cs), .TP_DCLK(dclk), .TP_DIN(din),
    .xaxis(xaxis), .yaxis(yaxis), .pen_down(pen_down), .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ADC model and reference state
  logic [23:0] exp_q[$];
  int          pulse = 0;
  logic [7:0]  cmd = 8'h00;
  logic [7:0]  expect_cmd = 8'hD0;
  logic [11:0] word = 12'h000, x_used = 12'h000;
  logic [11:0] x_val = 12'hA5C, y_val = 12'h3F1;
  bit          pen_ok = 0, abort = 1, first_after_rst = 1;
  time         t_cs_fall = 0, t_cs_rise = 0, t_din = 0;
  int          cs_falls = 0, valids = 0;
  logic        prev_valid = 1'b0;

  always @(din) t_din = $time;

  always @(posedge clk) if (penirq) pen_ok = 0;

  always @(negedge cs) begin
    cs_falls++;
    pulse = 0;
    cmd   = 8'h00;
    dout  = 1'b1;
    if (!first_after_rst) check("cs_high_gap", 32'(int'($time - t_cs_rise) >= GAP * T), 32'd1);
    first_after_rst = 0;
    abort = 0;
    t_cs_fall = $time;
    if (expect_cmd == 8'hD0) pen_ok = 1;
  end

  always @(posedge cs) begin
    t_cs_rise = $time;
    if (!abort) begin
      check("cs_low_time", 32'(int'($time - t_cs_fall)), 32'(49 * DIV * T));
      check("dclk_pulses", 32'(pulse), 32'd24);
      check("cmd_byte", 32'(cmd), 32'(expect_cmd));
      if (cmd == 8'h90 && pen_ok) exp_q.push_back({x_used, word});
      expect_cmd = (cmd == 8'hD0 && pen_ok) ? 8'h90 : 8'hD0;
    end
  end

  // The ADC presents the bit for pulse n+1 just after rising edge n
  always @(posedge dclk) begin
    if (cs === 1'b0) begin
      pulse++;
      if (pulse <= 8) cmd = {cmd[6:0], din};
      check("din_setup", 32'(int'($time - t_din) >= DIV * T), 32'd1);
      if (pulse == 9) begin
        word = (cmd == 8'hD0) ? x_val : y_val;
        if (cmd == 8'hD0) x_used = x_val;
      end
      if (pulse >= 9 && pulse <= 20) dout = word[20 - pulse];
      else dout = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every sample_valid
  always @(negedge clk) begin
    logic [23:0] e;
    if (sample_valid === 1'b1) begin
      valids++;
      check("valid_width", 32'(prev_valid), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sample: got x=%h y=%h, expected no sample", xaxis, yaxis);
      end else begin
        e = exp_q.pop_front();
        check("xaxis", 32'(xaxis), 32'(e[23:12]));
        check("yaxis", 32'(yaxis), 32'(e[11:0]));
      end
    end
    prev_valid = sample_valid;
  end

  task automatic wait_valids(input int target, input string name);
    int n = 0;
    while (valids < target && n < 1500) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(valids >= target), 32'd1);
  endtask

  task automatic wait_pulse(input int p, input logic [7:0] c, input string name);
    int n = 0;
    while (!(cs === 1'b0 && pulse == p && cmd == c) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < 3000), 32'd1);
  endtask

  initial begin
    logic [11:0] lx, ly;
    int bad, v0, f0;

    repeat (3) @(negedge clk);
    check("rst_cs", 32'(cs), 32'd1);
    check("rst_dclk", 32'(dclk), 32'd0);
    check("rst_din", 32'(din), 32'd0);
    check("rst_xaxis", 32'(xaxis), 32'd0);
    check("rst_yaxis", 32'(yaxis), 32'd0);
    check("rst_pen_down", 32'(pen_down), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    rst_n = 1'b1;

    // Pen up: nothing must happen
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (cs !== 1'b1 || dclk !== 1'b0 || sample_valid !== 1'b0) bad++;
    end
    check("idle_bus", 32'(bad), 32'd0);
    check("idle_frames", 32'(cs_falls), 32'd0);
    check("idle_xaxis", 32'(xaxis), 32'd0);
    check("idle_yaxis", 32'(yaxis), 32'd0);

    // Directed first pair
    penirq = 1'b0;
    @(negedge clk);
    check("pen_lag1", 32'(pen_down), 32'd0);
    @(negedge clk);
    check("pen_lag2", 32'(pen_down), 32'd1);
    wait_valids(1, "first_pair_timeout");
    check("first_x", 32'(xaxis), 32'hA5C);
    check("first_y", 32'(yaxis), 32'h3F1);

    // Randomized pairs plus the extreme codes
    for (int i = 0; i < 6; i++) begin
      x_val = 12'($urandom);
      y_val = 12'($urandom);
      if (i == 2) begin x_val = 12'h000; y_val = 12'hFFF; end
      if (i == 3) begin x_val = 12'hFFF; y_val = 12'h000; end
      wait_valids(valids + 1, "pair_timeout");
      if (i == 2) begin
        check("zero_x", 32'(xaxis), 32'h000);
        check("full_y", 32'(yaxis), 32'hFFF);
      end
    end
    lx = x_val;
    ly = y_val;

    // Pen lifted in the middle of the next Y frame
    x_val = 12'($urandom);
    y_val = 12'($urandom);
    wait_pulse(12, 8'h90, "y_frame_timeout");
    penirq = 1'b1;
    v0 = valids;
    repeat (300) @(negedge clk);
    f0 = cs_falls;
    repeat (300) @(negedge clk);
    check("lift_no_valid", 32'(valids), 32'(v0));
    check("lift_hold_x", 32'(xaxis), 32'(lx));
    check("lift_hold_y", 32'(yaxis), 32'(ly));
    check("lift_cs", 32'(cs), 32'd1);
    check("lift_dclk", 32'(dclk), 32'd0);
    check("lift_idle", 32'(cs_falls), 32'(f0));
    check("lift_pen_down", 32'(pen_down), 32'd0);

    // Reset at pulse 15 of an X frame, pen still down
    x_val = 12'($urandom);
    y_val = 12'($urandom);
    penirq = 1'b0;
    wait_pulse(15, 8'hD0, "x_frame_timeout");
    abort = 1;
    first_after_rst = 1;
    expect_cmd = 8'hD0;
    pen_ok = 0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_cs", 32'(cs), 32'd1);
    check("midrst_dclk", 32'(dclk), 32'd0);
    check("midrst_xaxis", 32'(xaxis), 32'd0);
    check("midrst_yaxis", 32'(yaxis), 32'd0);
    check("midrst_valid", 32'(sample_valid), 32'd0);
    rst_n = 1'b1;
    wait_valids(valids + 1, "post_rst_timeout");
    check("post_rst_x", 32'(xaxis), 32'(x_val));
    check("post_rst_y", 32'(yaxis), 32'(y_val));

    for (int i = 0; i < 2; i++) begin
      x_val = 12'($urandom);
      y_val = 12'($urandom);
      wait_valids(valids + 1, "tail_pair_timeout");
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
